// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU and DMA request ports plus the shared memory port.
// slave = arbiter side; master = requesters and memory side.
interface mem_arbiter_if;
   logic        I_c_req;
   logic        I_c_we;
   logic [31:0] I_c_addr;
   logic [31:0] I_c_data;
   logic [3:0]  I_c_mask;
   logic [31:0] O_c_data;
   logic        O_c_ack;
   logic        I_d_req;
   logic        I_d_we;
   logic [31:0] I_d_addr;
   logic [31:0] I_d_data;
   logic [3:0]  I_d_mask;
   logic [31:0] O_d_data;
   logic        O_d_ack;
   logic [31:0] O_m_addr;
   logic [31:0] O_m_data;
   logic [3:0]  O_m_mask;
   logic        O_m_we;
   logic [31:0] I_m_data;
   logic        I_m_stall;
   logic        O_busy;

   modport slave (
      input  I_c_req, I_c_we, I_c_addr, I_c_data, I_c_mask,
      input  I_d_req, I_d_we, I_d_addr, I_d_data, I_d_mask,
      input  I_m_data, I_m_stall,
      output O_c_data, O_c_ack, O_d_data, O_d_ack,
      output O_m_addr, O_m_data, O_m_mask, O_m_we, O_busy
   );

   modport master (
      output I_c_req, I_c_we, I_c_addr, I_c_data, I_c_mask,
      output I_d_req, I_d_we, I_d_addr, I_d_data, I_d_mask,
      output I_m_data, I_m_stall,
      input  O_c_data, O_c_ack, O_d_data, O_d_ack,
      input  O_m_addr, O_m_data, O_m_mask, O_m_we, O_busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a CPU and a DMA requester.
// Ports: I_clk, I_rst (async, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
   parameter bit CPU_PRIO = 1'b0
) (
   input logic           I_clk,
   input logic           I_rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDATA, DONE} state_t;

   state_t      state_q;
   logic        owner_q;
   logic        last_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_data_q;
   logic [3:0]  m_mask_q;
   logic        m_we_q;
   logic [31:0] c_data_q;
   logic [31:0] d_data_q;
   logic        c_ack_q;
   logic        d_ack_q;
   logic        busy_q;

   logic        any_req;
   logic        dma_d;

   // owner/last encoding: 1 = DMA, 0 = CPU
   always_comb begin
      any_req = bus.I_c_req | bus.I_d_req;
      if (!bus.I_c_req) begin
         dma_d = 1'b1;
      end else if (!bus.I_d_req) begin
         dma_d = 1'b0;
      end else if (CPU_PRIO) begin
         dma_d = 1'b0;
      end else begin
         // tie: whoever was not granted last
         dma_d = ~last_q;
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         m_addr_q <= '0;
         m_data_q <= '0;
         m_mask_q <= '0;
         m_we_q   <= 1'b0;
         c_data_q <= '0;
         d_data_q <= '0;
         c_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q  <= dma_d;
                  last_q   <= dma_d;
                  m_addr_q <= dma_d ? bus.I_d_addr : bus.I_c_addr;
                  m_data_q <= dma_d ? bus.I_d_data : bus.I_c_data;
                  m_mask_q <= dma_d ? bus.I_d_mask : bus.I_c_mask;
                  m_we_q   <= dma_d ? bus.I_d_we   : bus.I_c_we;
                  busy_q   <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.I_m_stall) begin
                  // we/mask only live during ISSUE; addr/data keep last value
                  m_we_q   <= 1'b0;
                  m_mask_q <= '0;
                  if (m_we_q) begin
                     c_ack_q <= ~owner_q;
                     d_ack_q <= owner_q;
                     state_q <= DONE;
                  end else begin
                     state_q <= RDATA;
                  end
               end
            end
            RDATA: begin
               if (owner_q) begin
                  d_data_q <= bus.I_m_data;
               end else begin
                  c_data_q <= bus.I_m_data;
               end
               c_ack_q <= ~owner_q;
               d_ack_q <= owner_q;
               state_q <= DONE;
            end
            DONE: begin
               c_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.O_c_data = c_data_q;
   assign bus.O_c_ack  = c_ack_q;
   assign bus.O_d_data = d_data_q;
   assign bus.O_d_ack  = d_ack_q;
   assign bus.O_m_addr = m_addr_q;
   assign bus.O_m_data = m_data_q;
   assign bus.O_m_mask = m_mask_q;
   assign bus.O_m_we   = m_we_q;
   assign bus.O_busy   = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (round-robin and CPU-priority builds).
// Requesters push expected responses; separate memory and ack monitors pop and compare.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus0 ();
   mem_arbiter_if bus1 ();

   mem_arbiter #(.CPU_PRIO(1'b0)) dut0 (.I_clk(clk), .I_rst(rst), .bus(bus0));
   mem_arbiter #(.CPU_PRIO(1'b1)) dut1 (.I_clk(clk), .I_rst(rst), .bus(bus1));

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] exp;
   } txn_t;

   int tests = 0;
   int fails = 0;

   txn_t cq[$];
   txn_t dq[$];
   int   ack_log[$];
   logic log_en = 1'b0;
   logic stall_rand = 1'b0;
   int   stall_left = 0;

   logic [31:0] mem  [logic [31:0]];
   logic [31:0] sh_c [logic [31:0]];
   logic [31:0] sh_d [logic [31:0]];

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] rdmem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction

   function automatic logic get_ack(input int w);
      return (w != 0) ? bus0.O_d_ack : bus0.O_c_ack;
   endfunction

   function automatic logic [159:0] outs(input int b);
      if (b == 0)
         return 160'({bus0.O_busy, bus0.O_c_ack, bus0.O_d_ack, bus0.O_c_data, bus0.O_d_data,
                      bus0.O_m_addr, bus0.O_m_data, bus0.O_m_mask, bus0.O_m_we});
      return 160'({bus1.O_busy, bus1.O_c_ack, bus1.O_d_ack, bus1.O_c_data, bus1.O_d_data,
                   bus1.O_m_addr, bus1.O_m_data, bus1.O_m_mask, bus1.O_m_we});
   endfunction

   // Reference model: each requester sees only its own writes, so the
   // expected read value is known the moment the request is made.
   task automatic issue_req(input int w, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
      txn_t t;
      logic [31:0] cur;
      if (w == 0) cur = sh_c.exists(a) ? sh_c[a] : init_val(a);
      else        cur = sh_d.exists(a) ? sh_d[a] : init_val(a);
      t.we = wr; t.addr = a; t.data = d; t.mask = m; t.exp = cur;
      if (wr) begin
         if (w == 0) sh_c[a] = merge(cur, d, m);
         else        sh_d[a] = merge(cur, d, m);
      end
      if (w == 0) begin
         cq.push_back(t);
         bus0.I_c_we = wr; bus0.I_c_addr = a; bus0.I_c_data = d; bus0.I_c_mask = m;
         bus0.I_c_req = 1'b1;
      end else begin
         dq.push_back(t);
         bus0.I_d_we = wr; bus0.I_d_addr = a; bus0.I_d_data = d; bus0.I_d_mask = m;
         bus0.I_d_req = 1'b1;
      end
   endtask

   task automatic wait_ack(input int w, input int limit, output int n, output int wec);
      n = 0;
      wec = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (bus0.O_m_we) wec++;
         if (get_ack(w)) break;
         if (n >= limit) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: requester %0d got no ack in %0d cycles, required ack", w, n);
            if (w == 0 && cq.size() > 0) void'(cq.pop_front());
            if (w != 0 && dq.size() > 0) void'(dq.pop_front());
            break;
         end
      end
      if (w == 0) bus0.I_c_req = 1'b0;
      else        bus0.I_d_req = 1'b0;
   endtask

   task automatic gen(input int w, input int n, input int gmax);
      int lat;
      int wc;
      logic [31:0] base;
      base = (w == 0) ? 32'h2000 : 32'h3000;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gmax, 0)) @(negedge clk);
         issue_req(w, 1'($urandom), base | (32'($urandom_range(15, 0)) << 2),
                   $urandom, 4'($urandom));
         wait_ack(w, 200, lat, wc);
      end
   endtask

   // Memory side: detects the issue phase (busy rising), checks the issued
   // fields, inserts stalls, and returns read data one cycle after issue.
   initial begin
      logic iss, bprev, rdp, first, s;
      logic [31:0] rdv;
      txn_t e;
      logic [68:0] held;
      iss = 0; bprev = 0; rdp = 0; first = 0; rdv = '0; held = '0;
      bus0.I_m_stall = 1'b0;
      bus0.I_m_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            iss = 0; bprev = 0; rdp = 0;
            bus0.I_m_stall = 1'b0;
         end else begin
            bus0.I_m_data = rdp ? rdv : $urandom;
            rdp = 0;
            if (bus0.O_busy && !bprev) begin
               iss = 1;
               first = 1;
            end
            bprev = bus0.O_busy;
            if (!iss) begin
               chk("idle_we_mask", 160'({bus0.O_m_we, bus0.O_m_mask}), 160'(0));
               bus0.I_m_stall = 1'($urandom);
            end else begin
               if (first) begin
                  e = '0;
                  if (cq.size() > 0 && cq[0].addr == bus0.O_m_addr) e = cq[0];
                  else if (dq.size() > 0) e = dq[0];
                  else if (cq.size() > 0) e = cq[0];
                  held = {bus0.O_m_addr, bus0.O_m_data, bus0.O_m_mask, bus0.O_m_we};
                  chk("issue_fields", 160'(held), 160'({e.addr, e.data, e.mask, e.we}));
                  first = 0;
               end else begin
                  chk("stall_hold",
                      160'({bus0.O_m_addr, bus0.O_m_data, bus0.O_m_mask, bus0.O_m_we}),
                      160'(held));
               end
               if (stall_left > 0) begin
                  s = 1;
                  stall_left--;
               end else begin
                  s = stall_rand && ($urandom_range(3, 0) == 0);
               end
               bus0.I_m_stall = s;
               if (!s) begin
                  iss = 0;
                  if (held[0]) mem[held[68:37]] = merge(rdmem(held[68:37]), held[36:5], held[4:1]);
                  else begin
                     rdp = 1;
                     rdv = rdmem(held[68:37]);
                  end
               end
            end
         end
      end
   end

   // Ack monitor: pops the owner's expected entry on each completion pulse.
   initial begin
      logic [31:0] last_c, last_d;
      logic pa_c, pa_d;
      txn_t t;
      last_c = '0; last_d = '0; pa_c = 0; pa_d = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_c = '0; last_d = '0; pa_c = 0; pa_d = 0;
            chk("ack_in_reset", 160'({bus0.O_c_ack, bus0.O_d_ack}), 160'(0));
         end else begin
            if (bus0.O_c_ack && bus0.O_d_ack) chk("dual_ack", 160'(2'b11), 160'(2'b00));
            if (bus0.O_c_ack) begin
               chk("c_ack_pulse", 160'(pa_c), 160'(0));
               if (cq.size() == 0) begin
                  chk("c_unexpected_ack", 160'(1), 160'(0));
               end else begin
                  t = cq.pop_front();
                  if (!t.we) last_c = t.exp;
                  chk("c_rdata", 160'(bus0.O_c_data), 160'(last_c));
                  chk("d_data_hold", 160'(bus0.O_d_data), 160'(last_d));
                  if (log_en) ack_log.push_back(0);
               end
            end
            if (bus0.O_d_ack) begin
               chk("d_ack_pulse", 160'(pa_d), 160'(0));
               if (dq.size() == 0) begin
                  chk("d_unexpected_ack", 160'(1), 160'(0));
               end else begin
                  t = dq.pop_front();
                  if (!t.we) last_d = t.exp;
                  chk("d_rdata", 160'(bus0.O_d_data), 160'(last_d));
                  chk("c_data_hold", 160'(bus0.O_c_data), 160'(last_c));
                  if (log_en) ack_log.push_back(1);
               end
            end
            pa_c = bus0.O_c_ack;
            pa_d = bus0.O_d_ack;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, wc, cacks, dacks;
      bus0.I_c_req = 0; bus0.I_c_we = 0; bus0.I_c_addr = '0; bus0.I_c_data = '0; bus0.I_c_mask = '0;
      bus0.I_d_req = 0; bus0.I_d_we = 0; bus0.I_d_addr = '0; bus0.I_d_data = '0; bus0.I_d_mask = '0;
      bus1.I_c_req = 0; bus1.I_c_we = 1; bus1.I_c_addr = 32'h10; bus1.I_c_data = '0; bus1.I_c_mask = 4'hF;
      bus1.I_d_req = 0; bus1.I_d_we = 1; bus1.I_d_addr = 32'h20; bus1.I_d_data = '0; bus1.I_d_mask = 4'hF;
      bus1.I_m_stall = 0; bus1.I_m_data = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(0), 160'(0));
      chk("reset_outputs_prio", outs(1), 160'(0));
      rst = 1'b0;
      @(negedge clk);

      issue_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      wait_ack(0, 20, n, wc);
      chk_i("wr_latency", n, 2);
      chk_i("wr_we_cycles", wc, 1);

      @(negedge clk);
      mem[32'h40]  = 32'h12345678;
      sh_d[32'h40] = 32'h12345678;
      issue_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
      wait_ack(1, 20, n, wc);
      chk_i("rd_latency", n, 3);
      chk("dma_rd_data", 160'(bus0.O_d_data), 160'(32'h12345678));

      @(negedge clk);
      stall_left = 3;
      issue_req(0, 1'b1, 32'h104, 32'hCAFE0001, 4'h5);
      wait_ack(0, 20, n, wc);
      chk_i("stall_latency", n, 5);
      chk_i("stall_we_cycles", wc, 4);

      @(negedge clk);
      issue_req(0, 1'b0, 32'h200, 32'h0, 4'h3);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_reset", outs(0), 160'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ack(0, 20, n, wc);
      chk_i("post_reset_latency", n, 3);

      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      stall_rand = 1'b1;
      log_en = 1'b1;
      fork
         gen(0, 4, 0);
         gen(1, 4, 0);
      join
      log_en = 1'b0;
      chk_i("rr_count", ack_log.size(), 8);
      for (int i = 0; i < ack_log.size() && i < 8; i++) chk_i("rr_order", ack_log[i], i % 2);

      fork
         gen(0, 40, 3);
         gen(1, 40, 3);
      join
      repeat (3) @(negedge clk);
      chk_i("cq_drained", cq.size(), 0);
      chk_i("dq_drained", dq.size(), 0);

      @(negedge clk);
      bus1.I_c_req = 1'b1;
      bus1.I_d_req = 1'b1;
      cacks = 0;
      dacks = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus1.O_c_ack) cacks++;
         if (bus1.O_d_ack) dacks++;
      end
      chk_i("prio_dma_blocked", dacks, 0);
      chk_i("prio_cpu_acks", cacks, 10);
      bus1.I_c_req = 1'b0;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (bus1.O_d_ack) break;
      end
      chk_i("prio_dma_after_cpu", n, 2);
      bus1.I_d_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
